// File: rtl/alu_issue.sv
// RV32I ALU issue: decodes OP/OP-IMM/LUI/AUIPC into ALU operands, queues them in a 2-entry skid buffer.
// Latency 1 cycle; in_ready is registered and drops only when both entries are occupied.
// Optional ALU_ISSUE_STATS_EN adds saturating issue_cnt / illegal_cnt counters.
module alu_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output logic [3:0]  aluSel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        illegal
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [15:0] issue_cnt,
    output logic [7:0]  illegal_cnt
`endif
);

    localparam logic [3:0] SEL_ADD   = 4'd0;
    localparam logic [3:0] SEL_SUB   = 4'd1;
    localparam logic [3:0] SEL_SLL   = 4'd2;
    localparam logic [3:0] SEL_SLT   = 4'd3;
    localparam logic [3:0] SEL_SLTU  = 4'd4;
    localparam logic [3:0] SEL_XOR   = 4'd5;
    localparam logic [3:0] SEL_SRL   = 4'd6;
    localparam logic [3:0] SEL_SRA   = 4'd7;
    localparam logic [3:0] SEL_OR    = 4'd8;
    localparam logic [3:0] SEL_AND   = 4'd9;
    localparam logic [3:0] SEL_COPY1 = 4'd10;

    typedef struct packed {
        logic [3:0]  sel;
        logic [31:0] op1;
        logic [31:0] op2;
    } uop_t;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       unused_rd;
    assign opcode    = instr[6:0];
    assign f3        = instr[14:12];
    assign f7        = instr[31:25];
    assign unused_rd = ^instr[11:7];

    uop_t dec;
    logic dec_ok;

    always_comb begin
        dec    = '0;
        dec_ok = 1'b0;
        case (opcode)
            7'b0110011: begin
                dec.op1 = rs1_data;
                dec.op2 = rs2_data;
                if (f7 == 7'b0000000) begin
                    dec_ok = 1'b1;
                    case (f3)
                        3'b000:  dec.sel = SEL_ADD;
                        3'b001:  dec.sel = SEL_SLL;
                        3'b010:  dec.sel = SEL_SLT;
                        3'b011:  dec.sel = SEL_SLTU;
                        3'b100:  dec.sel = SEL_XOR;
                        3'b101:  dec.sel = SEL_SRL;
                        3'b110:  dec.sel = SEL_OR;
                        default: dec.sel = SEL_AND;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    dec_ok  = 1'b1;
                    dec.sel = SEL_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    dec_ok  = 1'b1;
                    dec.sel = SEL_SRA;
                end
            end
            7'b0010011: begin
                dec.op1 = rs1_data;
                dec.op2 = {{20{instr[31]}}, instr[31:20]};
                dec_ok  = 1'b1;
                case (f3)
                    3'b000: dec.sel = SEL_ADD;
                    3'b001: begin
                        dec.sel = SEL_SLL;
                        dec_ok  = (f7 == 7'b0000000);
                    end
                    3'b010: dec.sel = SEL_SLT;
                    3'b011: dec.sel = SEL_SLTU;
                    3'b100: dec.sel = SEL_XOR;
                    3'b101: begin
                        // shift immediates carry the arithmetic flag in instr[30]
                        dec.sel = (f7 == 7'b0100000) ? SEL_SRA : SEL_SRL;
                        dec_ok  = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    end
                    3'b110:  dec.sel = SEL_OR;
                    default: dec.sel = SEL_AND;
                endcase
            end
            7'b0110111: begin
                dec_ok  = 1'b1;
                dec.sel = SEL_COPY1;
                dec.op1 = {instr[31:12], 12'b0};
            end
            7'b0010111: begin
                dec_ok  = 1'b1;
                dec.sel = SEL_ADD;
                dec.op1 = pc;
                dec.op2 = {instr[31:12], 12'b0};
            end
            default: dec_ok = 1'b0;
        endcase
    end

    uop_t       head;
    uop_t       tail;
    logic [1:0] cnt;
    logic [1:0] cnt_nxt;
    logic       acc;
    logic       enq;
    logic       deq;

    assign out_valid = (cnt != 2'd0);
    assign op1       = head.op1;
    assign op2       = head.op2;
    assign aluSel    = head.sel;
    assign acc       = in_valid && in_ready;
    assign enq       = acc && dec_ok;
    assign deq       = out_valid && out_ready;

    always_comb begin
        cnt_nxt = cnt;
        if (enq && !deq)
            cnt_nxt = cnt + 2'd1;
        else if (deq && !enq)
            cnt_nxt = cnt - 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= 2'd0;
            head     <= '0;
            tail     <= '0;
            in_ready <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            in_ready <= (cnt_nxt != 2'd2);
            illegal  <= acc && !dec_ok;
            if (deq) begin
                // enqueue alongside dequeue only happens with one entry, so new data becomes head
                if (enq)
                    head <= dec;
                else if (cnt == 2'd2)
                    head <= tail;
            end else if (enq) begin
                if (cnt == 2'd0)
                    head <= dec;
                else
                    tail <= dec;
            end
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt   <= 16'd0;
            illegal_cnt <= 8'd0;
        end else begin
            if (deq && issue_cnt != 16'hFFFF)
                issue_cnt <= issue_cnt + 16'd1;
            if (acc && !dec_ok && illegal_cnt != 8'hFF)
                illegal_cnt <= illegal_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue: decode vectors, illegal pulses, backpressure, reset flush.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  aluSel;
    logic        out_valid;
    logic        out_ready;
    logic        illegal;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] issue_cnt;
    logic [7:0]  illegal_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc        (pc),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .op1       (op1),
        .op2       (op2),
        .aluSel    (aluSel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .illegal   (illegal)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .issue_cnt   (issue_cnt),
        .illegal_cnt (illegal_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        instr    = i;
        pc       = p;
        rs1_data = a;
        rs2_data = b;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue_chk(input string tag, input logic [31:0] i, input logic [31:0] p,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] sel, input logic [31:0] e1, input logic [31:0] e2);
        drive(i, p, a, b);
        step();
        chk({tag, ".vld"}, out_valid, 1);
        chk({tag, ".sel"}, aluSel, sel);
        chk({tag, ".op1"}, op1, e1);
        chk({tag, ".op2"}, op2, e2);
        chk({tag, ".ill"}, illegal, 0);
    endtask

    task automatic illegal_chk(input string tag, input logic [31:0] i);
        drive(i, 32'h0, 32'h1, 32'h2);
        step();
        chk({tag, ".pulse"}, illegal, 1);
        chk({tag, ".vld"}, out_valid, 0);
        in_valid = 1'b0;
        step();
        chk({tag, ".pulse_end"}, illegal, 0);
        chk({tag, ".vld2"}, out_valid, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        instr     = '0;
        pc        = '0;
        rs1_data  = '0;
        rs2_data  = '0;
        out_ready = 1'b1;
        #3;
        chk("rst.in_ready", in_ready, 0);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.illegal", illegal, 0);
        chk("rst.op1", op1, 0);
        chk("rst.op2", op2, 0);
        chk("rst.sel", aluSel, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst.in_ready", in_ready, 1);

        // back-to-back stream with out_ready high: one bundle per cycle
        issue_chk("sub",   32'h40208033, 32'h0,   32'd10,       32'd3, 4'd1,  32'd10,       32'd3);
        issue_chk("slti",  32'hFFF0A093, 32'h0,   32'd5,        32'd7, 4'd3,  32'd5,        32'hFFFFFFFF);
        issue_chk("auipc", 32'h12345017, 32'h100, 32'd9,        32'd9, 4'd0,  32'h100,      32'h12345000);
        issue_chk("lui",   32'hABCDE0B7, 32'h40,  32'd9,        32'd9, 4'd10, 32'hABCDE000, 32'h0);
        issue_chk("srai",  32'h4030D093, 32'h0,   32'h80000000, 32'd1, 4'd7,  32'h80000000, 32'h00000403);
        issue_chk("or",    32'h0020E033, 32'h0,   32'h0F0F0000, 32'h1, 4'd8,  32'h0F0F0000, 32'h1);

        illegal_chk("jal", 32'h0000006F);
`ifdef ALU_ISSUE_STATS_EN
        chk("stats.illegal_cnt", illegal_cnt, 1);
        chk("stats.issue_cnt", issue_cnt, 6);
`endif
        illegal_chk("op_f7", 32'h40209033);
        illegal_chk("slli_f7", 32'h40209093);

        // backpressure: third bundle must wait until the buffer drains
        out_ready = 1'b0;
        drive(32'h00000033, 32'h0, 32'd1, 32'd0);
        step();
        chk("bp.a.in_ready", in_ready, 1);
        chk("bp.a.op1", op1, 1);
        drive(32'h00000033, 32'h0, 32'd2, 32'd0);
        step();
        chk("bp.b.in_ready", in_ready, 0);
        chk("bp.b.hold", op1, 1);
        drive(32'h00000033, 32'h0, 32'd3, 32'd0);
        step();
        chk("bp.c.in_ready", in_ready, 0);
        chk("bp.c.hold", op1, 1);
        chk("bp.c.vld", out_valid, 1);
        out_ready = 1'b1;
        step();
        chk("bp.drain1.op1", op1, 2);
        chk("bp.drain1.in_ready", in_ready, 1);
        step();
        chk("bp.drain2.op1", op1, 3);
        chk("bp.drain2.vld", out_valid, 1);
        in_valid = 1'b0;
        step();
        chk("bp.empty", out_valid, 0);

        // reset with two bundles buffered must discard them
        out_ready = 1'b0;
        drive(32'h00000033, 32'h0, 32'h11, 32'h0);
        step();
        drive(32'h00000033, 32'h0, 32'h22, 32'h0);
        step();
        chk("rst2.full_vld", out_valid, 1);
        chk("rst2.full_rdy", in_ready, 0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2.vld", out_valid, 0);
        chk("rst2.in_ready", in_ready, 0);
        chk("rst2.op1", op1, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        chk("rst2.rel_rdy", in_ready, 1);
        chk("rst2.rel_vld", out_valid, 0);
        step();
        chk("rst2.no_stale", out_valid, 0);
`ifdef ALU_ISSUE_STATS_EN
        chk("rst2.issue_cnt", issue_cnt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, instruction/operand bundle present.
REQ-004 SHALL have port in_ready, output, 1, bundle accepted when in_valid && in_ready.
REQ-005 SHALL have port instr, input, 32, RV32I instruction word.
REQ-006 SHALL have port pc, input, 32, instruction address.
REQ-007 SHALL have port rs1_data, input, 32, register-file read of rs1.
REQ-008 SHALL have port rs2_data, input, 32, register-file read of rs2.
REQ-009 SHALL have port op1, output, 32, ALU operand 1.
REQ-010 SHALL have port op2, output, 32, ALU operand 2.
REQ-011 SHALL have port aluSel, output, 4, encoding ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9 COPY1=10.
REQ-012 SHALL have port out_valid, output, 1, op1/op2/aluSel valid; out_ready, input, 1, downstream ALU stage accepts.
REQ-013 SHALL have port illegal, output, 1, one-cycle pulse when an accepted instruction is undecodable.

Function
REQ-014 SHALL decode OP (0110011): funct3/funct7 -> ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND; op1=rs1_data, op2=rs2_data; funct7 other than 0000000, or 0100000 with funct3 not in {000,101}, is illegal.
REQ-015 SHALL decode OP-IMM (0010011): op1=rs1_data, op2=sign-extended instr[31:20]; SLLI/SRLI require instr[31:25]=0000000, SRAI requires 0100000, else illegal; no SUBI.
REQ-016 SHALL decode LUI (0110111): aluSel=COPY1, op1={instr[31:12],12'b0}, op2=0.
REQ-017 SHALL decode AUIPC (0010111): aluSel=ADD, op1=pc, op2={instr[31:12],12'b0}.
REQ-018 SHALL treat every other opcode as illegal; illegal bundles are consumed (in_ready honoured), never enqueued, and pulse illegal in the cycle after acceptance.
REQ-019 SHALL hold decoded bundles in a 2-entry skid buffer; outputs driven from the head entry register, never combinationally from inputs.
REQ-020 SHALL assert in_ready iff buffer holds fewer than 2 entries (registered, not dependent on out_ready).
REQ-021 SHALL give latency 1 cycle: bundle accepted at edge N with empty buffer appears with out_valid=1 after edge N.
REQ-022 SHALL sustain 1 bundle/cycle when out_ready is held high.
REQ-023 SHALL keep op1/op2/aluSel stable while out_valid && !out_ready.
REQ-024 SHALL handle simultaneous enqueue and dequeue in the same cycle with count unchanged and order preserved; full buffer with out_ready=1 accepts no new bundle that cycle (in_ready=0) and drains one.

Reset
REQ-025 SHALL, on rst_n low, immediately clear buffer count, out_valid=0, illegal=0, in_ready=0; op1=op2=0, aluSel=ADD.
REQ-026 SHALL assert in_ready in first cycle after rst_n deasserts; bundles buffered when reset asserts mid-operation are discarded.

Configuration
REQ-027 SHALL, with ALU_ISSUE_STATS_EN defined, provide output issue_cnt (16) counting bundles dequeued (out_valid && out_ready) and output illegal_cnt (8) counting illegal pulses, both saturating at all-ones, reset to 0.
REQ-028 SHALL, without ALU_ISSUE_STATS_EN, omit issue_cnt and illegal_cnt ports and counters entirely; all other behaviour identical.

Verification
REQ-029 SHALL cover: instr=0x40208033 (SUB x0,x1,x2), rs1=10, rs2=3, out_ready=1 -> next cycle out_valid=1, aluSel=1, op1=10, op2=3.
REQ-030 SHALL cover: instr=0xFFF0A093 (SLTI... use ADDI-class opcode, funct3=010, imm=-1), rs1=5 -> aluSel=3, op2=0xFFFFFFFF.
REQ-031 SHALL cover: instr=0x12345017 (AUIPC), pc=0x100 -> aluSel=0, op1=0x100, op2=0x12345000.
REQ-032 SHALL cover: out_ready=0, three back-to-back valid bundles -> first two accepted, in_ready=0 on third; out_ready=1 then drains in order, third accepted.
REQ-033 SHALL cover: instr=0x0000006F (JAL) -> illegal pulses 1 cycle, out_valid stays 0; with ALU_ISSUE_STATS_EN illegal_cnt=1.
REQ-034 SHALL cover: rst_n pulled low with 2 bundles buffered -> out_valid=0 immediately; after release in_ready=1, no stale bundle emitted.
